// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the two-digit countdown controller:
//   - state_t     : controller states (IDLE, RUN, PAUSED, EXPIRED)
//   - COUNT_W     : width of the displayed count (7 bits, 0..99)
//   - MAX_COUNT   : largest displayable count (99)
//   - clamp_count : saturates a raw load value to MAX_COUNT
// -----------------------------------------------------------------------------
package countdown_pkg;

    localparam int COUNT_W = 7;
    localparam logic [COUNT_W-1:0] MAX_COUNT = 7'd99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_CYCLES counter that produces the countdown tick.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   clear  in  force the count back to 0 (wins over enable)
//   enable in  advance the count; the count is held while low
//   tick   out one-cycle pulse while enabled at the terminal count; the
//              count wraps to 0 on that same edge
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_at_terminal;

    assign w_at_terminal = (r_count == TERMINAL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_terminal ? '0 : r_count + CW'(1);
        end
    end

    // Combinational from the registered count, so the controller decrements
    // on the very edge at which the count wraps.
    assign tick = enable && w_at_terminal;

endmodule

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Sequencing controller for the two-digit countdown display. Holds a 0..99
// count, decrements it once per prescaled tick while running, supports
// load/start/pause and flags expiry. Input priority in every state is
// load > pause > start.
//
// Configuration macro: BLINK_ON_EXPIRY_EN
//   defined   : in EXPIRED, blank toggles every BLINK_CYCLES cycles starting
//               at 0 on entry; blank is 0 in every other state.
//   undefined : blank is tied 0 and no blink counter exists.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   load          in   pulse: capture min(load_value, 99), go IDLE
//   load_value    in   7-bit start value
//   start         in   pulse: begin (IDLE, count != 0) or resume (PAUSED)
//   pause         in   pulse: freeze counting (RUN only)
//   number        out  current count 0..99 (registered)
//   running       out  high in RUN (registered)
//   expired       out  high in EXPIRED (registered)
//   expired_pulse out  one-cycle pulse on entry to EXPIRED (registered)
//   blank         out  segment blanking request (registered)
//   state_dbg     out  current controller state, for observation
//
// Handshake: all control inputs are single-cycle pulses sampled on the rising
// edge; there is no back-pressure, every pulse is acted on (or ignored per
// state) on the edge where it is high.
// -----------------------------------------------------------------------------
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               start,
    input  logic               pause,
    output logic [COUNT_W-1:0] number,
    output logic               running,
    output logic               expired,
    output logic               expired_pulse,
    output logic               blank,
    output state_t             state_dbg
);

    // Reject illegal parameterisations at elaboration.
    if (TICK_CYCLES < 2) begin : g_bad_tick
        $error("countdown_ctrl: TICK_CYCLES must be >= 2");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
        $error("countdown_ctrl: BLINK_CYCLES must be >= 1");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COUNT_W-1:0] r_number;
    logic [COUNT_W-1:0] w_number_nxt;
    logic               r_running;
    logic               r_expired;
    logic               r_expired_pulse;
    logic               w_pulse_nxt;
    logic               w_presc_clear;
    logic               w_presc_enable;
    logic               w_tick;

    // The prescaler runs only while the registered state is RUN; a pause
    // seen in RUN still lets that edge count, which keeps pause/resume free
    // of extra cycles.
    assign w_presc_enable = (r_state == RUN);

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_presc_clear),
        .enable (w_presc_enable),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_number_nxt  = r_number;
        w_presc_clear = 1'b0;
        w_pulse_nxt   = 1'b0;

        if (load) begin
            w_number_nxt  = clamp_count(load_value);
            w_presc_clear = 1'b1;
            w_state_nxt   = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!pause && start && (r_number != '0)) begin
                        w_state_nxt   = RUN;
                        w_presc_clear = 1'b1;
                    end
                end
                RUN: begin
                    // A tick coinciding with pause still decrements; reaching
                    // zero wins over pausing.
                    if (w_tick) begin
                        w_number_nxt = r_number - COUNT_W'(1);
                        if (r_number == COUNT_W'(1)) begin
                            w_state_nxt = EXPIRED;
                            w_pulse_nxt = 1'b1;
                        end else if (pause) begin
                            w_state_nxt = PAUSED;
                        end
                    end else if (pause) begin
                        w_state_nxt = PAUSED;
                    end
                end
                PAUSED: begin
                    if (!pause && start) begin
                        w_state_nxt = RUN;
                    end
                end
                EXPIRED: begin
                    w_state_nxt = EXPIRED;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_number        <= '0;
            r_running       <= 1'b0;
            r_expired       <= 1'b0;
            r_expired_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_number        <= w_number_nxt;
            r_running       <= (w_state_nxt == RUN);
            r_expired       <= (w_state_nxt == EXPIRED);
            r_expired_pulse <= w_pulse_nxt;
        end
    end

`ifdef BLINK_ON_EXPIRY_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_TERMINAL = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blank;

    // Counting only while staying in EXPIRED; entry, exit and every other
    // state hold the counter and blank at 0, so each expiry starts unblanked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if ((r_state == EXPIRED) && (w_state_nxt == EXPIRED)) begin
            if (r_blink_cnt == BLINK_TERMINAL) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end else begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end
    end

    assign blank = r_blank;
`else
    assign blank = 1'b0;
`endif

    assign number        = r_number;
    assign running       = r_running;
    assign expired       = r_expired;
    assign expired_pulse = r_expired_pulse;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
// Drives countdown_ctrl with directed scenarios followed by random pulses.
// A behavioural model predicts every change of the observable outputs and
// queues it with the cycle it must appear in; a monitor pops and compares
// whenever the DUT's outputs change.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;
    import countdown_pkg::*;

    localparam int TICK  = 4;
    localparam int BLINK = 2;
    localparam int TW    = 11;  // {number, running, expired, pulse, blank}
    localparam int QW    = 32;  // {cycle[20:0], tuple}

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_EXP    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n      = 1'b0;
    logic         load       = 1'b0;
    logic [6:0]   load_value = 7'd0;
    logic         start      = 1'b0;
    logic         pause      = 1'b0;
    logic [6:0]   number;
    logic         running;
    logic         expired;
    logic         expired_pulse;
    logic         blank;
    state_t       state_dbg;

    countdown_ctrl #(
        .TICK_CYCLES  (TICK),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .load_value    (load_value),
        .start         (start),
        .pause         (pause),
        .number        (number),
        .running       (running),
        .expired       (expired),
        .expired_pulse (expired_pulse),
        .blank         (blank),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [QW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int  m_mode    = M_IDLE;
    int  m_num     = 0;
    int  m_elapsed = 0;   // running cycles since the last decrement
    int  m_age     = 0;   // cycles spent in EXPIRED since entry
    bit  m_pulse   = 1'b0;
    bit  m_have_last = 1'b0;
    logic [TW-1:0] m_last;

    task automatic model_update(input bit l, input int lv, input bit s, input bit p, input bit r);
        logic [TW-1:0] t;
        bit            b;
        m_pulse = 1'b0;
        if (!r) begin
            m_mode = M_IDLE; m_num = 0; m_elapsed = 0; m_age = 0;
        end else if (l) begin
            m_num = (lv > 99) ? 99 : lv;
            m_mode = M_IDLE;
            m_elapsed = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (!p && s && m_num != 0) begin
                    m_mode = M_RUN; m_elapsed = 0;
                end
                M_RUN: begin
                    m_elapsed++;
                    if (m_elapsed == TICK) begin
                        m_elapsed = 0;
                        m_num--;
                        if (m_num == 0) begin
                            m_mode = M_EXP; m_pulse = 1'b1; m_age = 0;
                        end else if (p) begin
                            m_mode = M_PAUSED;
                        end
                    end else if (p) begin
                        m_mode = M_PAUSED;
                    end
                end
                M_PAUSED: if (!p && s) m_mode = M_RUN;
                default: m_age++;
            endcase
        end
`ifdef BLINK_ON_EXPIRY_EN
        b = (m_mode == M_EXP) && (((m_age / BLINK) % 2) == 1);
`else
        b = 1'b0;
`endif
        t = {7'(m_num), m_mode == M_RUN, m_mode == M_EXP, m_pulse, b};
        if (!m_have_last || t != m_last) begin
            exp_q.push_back({21'(cyc), t});
            m_last = t;
            m_have_last = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit l, input logic [6:0] lv, input bit s, input bit p, input bit r);
        load = l; load_value = lv; start = s; pause = p; rst_n = r;
        @(posedge clk); #1;
        model_update(l, int'(lv), s, p, r);
        load = 1'b0; start = 1'b0; pause = 1'b0; rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_load(input logic [6:0] v);
        step(1'b1, v, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_start();
        step(1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_pause();
        step(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
    endtask

    // ---------------- monitor ----------------
    logic [TW-1:0] mon_last;
    logic [TW-1:0] mon_now;
    logic [QW-1:0] mon_exp;
    bit            mon_have = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon_now = {number, running, expired, expired_pulse, blank};
            if (!mon_have || mon_now !== mon_last) begin
                mon_have = 1'b1;
                mon_last = mon_now;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cycle=%0d got num=%0d run=%0b exp=%0b pulse=%0b blank=%0b required no change",
                             cyc, mon_now[10:4], mon_now[3], mon_now[2], mon_now[1], mon_now[0]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_exp !== {21'(cyc), mon_now}) begin
                        n_fail++;
                        $display("FAIL output_event cycle=%0d got num=%0d run=%0b exp=%0b pulse=%0b blank=%0b required cycle=%0d num=%0d run=%0b exp=%0b pulse=%0b blank=%0b",
                                 cyc, mon_now[10:4], mon_now[3], mon_now[2], mon_now[1], mon_now[0],
                                 mon_exp[31:11], mon_exp[10:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset while in RUN.
        step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        do_load(7'd9);
        do_start();
        idle(5);
        step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Load 3 and run to expiry, then watch the expired display.
        do_load(7'd3);
        idle(2);
        do_start();
        idle(16);
        do_start();
        do_pause();
        idle(4);
        do_load(7'd2);
        idle(2);

        // Clamp and zero-start.
        do_load(7'd120);
        idle(2);
        do_load(7'd0);
        do_start();
        idle(6);

        // Pause two cycles in, hold, resume.
        do_load(7'd10);
        do_start();
        idle(1);
        do_pause();
        idle(20);
        do_pause();
        do_start();
        idle(5);

        // Pause exactly on a tick.
        for (int k = 0; k < 2 * TICK && m_elapsed != TICK - 1; k++) idle(1);
        do_pause();
        idle(4);
        do_start();
        idle(6);

        // load + start + pause together while running at 5.
        do_load(7'd6);
        do_start();
        for (int k = 0; k < 4 * TICK && !(m_num == 5 && m_mode == M_RUN); k++) idle(1);
        step(1'b1, 7'd7, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Expire from 1, then load leaves EXPIRED.
        do_load(7'd1);
        do_start();
        idle(12);
        do_load(7'd4);
        idle(2);

        // Random pulses.
        for (int k = 0; k < 700; k++) begin
            logic [6:0] v;
            bit l, s, p, r;
            v = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
            l = ($urandom_range(0, 99) < 4);
            s = ($urandom_range(0, 99) < 12);
            p = ($urandom_range(0, 99) < 6);
            r = ($urandom_range(0, 199) != 0);
            step(l, v, s, p, r);
        end
        idle(4);

        // Every predicted event must have been observed.
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d pending events required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the two-digit countdown display path. Holds the game's 0–99 countdown value, decrements it once per prescaled tick while running, supports load/start/pause, and flags expiry. Its `number` output feeds the `SevenSegment2digit` converter directly. Its `blank` output lets the top level suppress the segments while the expired display blinks.

## Interface
Parameters:
- TICK_CYCLES, 50_000_000: clk cycles per countdown decrement (≥2)
- BLINK_CYCLES, 12_500_000: clk cycles per `blank` toggle in EXPIRED (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- load  in  1  single-cycle pulse; capture `load_value`
- load_value  in  7  start value; values >99 clamp to 99
- start  in  1  single-cycle pulse; begin or resume counting
- pause  in  1  single-cycle pulse; freeze counting
- number  out  7  current count 0–99, to the 2-digit converter
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- expired_pulse  out  1  one-cycle pulse on entry to EXPIRED
- blank  out  1  segment blanking request

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Priority in every state: `load` > `pause` > `start`.
- Load from any state: `number` ← min(load_value, 99), prescaler ← 0, state ← IDLE.
- IDLE:
  - `start` with number≠0 → RUN, prescaler ← 0.
  - `start` with number=0 → ignored.
- RUN: prescaler counts 0..TICK_CYCLES-1 and wraps. At terminal count, `number` decrements.
  - If the decrement makes `number` 0 → EXPIRED, with `expired_pulse` high for that one cycle.
  - `pause` → PAUSED; the prescaler value is held.
  - `pause` coinciding with terminal count: the decrement still happens, then PAUSED, or EXPIRED if the count reaches 0. EXPIRED takes precedence over PAUSED.
- PAUSED: `start` → RUN; the prescaler resumes from its held value. `pause` is ignored.
- EXPIRED: `number` stays 0. `start` and `pause` are ignored. Only `load` or reset leaves this state.
- `number` never underflows and never exceeds 99.

## Timing
- Reset values: state IDLE, number 0, running 0, expired 0, expired_pulse 0, blank 0, prescaler 0, blink counter 0.
- Reset mid-operation: all of the above are restored on the next edge, regardless of state.
- `load` at edge N: `number` shows the new value after edge N.
- `start` at edge N: `running`=1 after edge N. The first decrement occurs exactly TICK_CYCLES edges later, and every TICK_CYCLES edges after that.
- Pause/resume adds no cycles beyond the paused interval.
- Segment outputs lag `number` by the converter's own register stages. This block does not compensate.

## Configuration
- BLINK_ON_EXPIRY_EN defined:
  - In EXPIRED, `blank` toggles every BLINK_CYCLES cycles, starting at 0 on entry.
  - The blink counter resets on entry to EXPIRED.
  - `blank` is forced to 0 in all other states.
- BLINK_ON_EXPIRY_EN undefined:
  - `blank` is tied 0 and no blink counter is built.
  - All other behaviour is identical.

## Structure
- Shared package `countdown_pkg` holds:
  - the state enum (IDLE, RUN, PAUSED, EXPIRED)
  - MAX_COUNT = 99
  - the 7-bit count width constant
- Sub-module `tick_prescaler`:
  - inputs: `clk`, `rst_n`, `clear`, `enable`
  - output: `tick`, a one-cycle pulse at terminal count
  - the count is held while `enable` is low
- FSM and count register live in `countdown_ctrl`.

## Test plan
All scenarios use TICK_CYCLES=4 and BLINK_CYCLES=2.
- Reset: rst_n low for 2 cycles while in RUN → next edge: number 0, IDLE, all flags 0.
- Load then run: load_value=3 (load), then start → number 3,2,1,0 at 4-cycle spacing; expired_pulse high exactly once; expired stays 1; running 0.
- Clamp and edge: load_value=120 → number 99. Load 0 then start → remains IDLE, running 0.
- Pause: load 10, start, pause 2 cycles in, hold 20 cycles, then start → next decrement after 2 more cycles. Also pause on a tick cycle → number decrements, then PAUSED.
- Priority: load=1, start=1 and pause=1 in the same cycle while in RUN at number 5 with load_value 7 → number 7, IDLE.
- Blink: with BLINK_ON_EXPIRY_EN, in EXPIRED `blank` reads 0,0,1,1,0,0…; load exits and `blank` is 0. Without the macro, `blank` is always 0.
